// File: rtl/lcd_row_writer.sv
// HD44780 16x2 character LCD writer: runs the power-up init sequence, then
// rewrites both display lines whenever the host rows differ from what is shown.
module lcd_row_writer #(
  parameter logic [15:0] POWERUP_CYCLES = 16'd40000,
  parameter logic [7:0]  EN_CYCLES      = 8'd20,
  parameter logic [7:0]  GAP_CYCLES     = 8'd80,
  parameter logic [15:0] CLEAR_CYCLES   = 16'd2000
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic [127:0] top,
  input  logic [127:0] bottom,
  output logic         lcd_en,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_data,
  output logic         busy,
  output logic         frame_done
);

  // LCD bus: rs/data change only when a byte starts and are held through the
  // en-high window and the following gap; the panel latches on en falling.
  typedef enum logic [3:0] {
    S_POWERUP,
    S_INIT,
    S_CLEAR_WAIT,
    S_IDLE,
    S_LINE1,
    S_WR_TOP,
    S_LINE2,
    S_WR_BOT,
    S_DONE
  } state_t;

  localparam logic [15:0] EN_LEN    = {8'd0, EN_CYCLES};
  localparam logic [15:0] BYTE_LAST = {8'd0, EN_CYCLES} + {8'd0, GAP_CYCLES} - 16'd1;
  localparam logic [255:0] BLANK    = {32{8'h20}};

  state_t        state, state_d;
  logic [15:0]   cnt, cnt_d;
  logic [3:0]    idx, idx_d;
  logic [255:0]  snapshot, shown;
  logic [255:0]  rows;
  logic          capture;
  logic          byte_last;
  logic          sending_d;
  logic          en_d;
  logic          load_d;
  logic          rs_d;
  logic [7:0]    byte_d;
  logic [6:0]    char_base;

  assign rows      = {top, bottom};
  assign byte_last = (cnt == BYTE_LAST);
  assign lcd_rw    = 1'b0;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= S_POWERUP;
      cnt   <= 16'd0;
      idx   <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt + 16'd1;
    idx_d   = idx;
    capture = 1'b0;
    case (state)
      S_POWERUP: begin
        if (cnt + 16'd1 >= POWERUP_CYCLES) begin
          state_d = S_INIT;
          cnt_d   = 16'd0;
          idx_d   = 4'd0;
        end
      end
      S_INIT: begin
        if (byte_last) begin
          cnt_d = 16'd0;
          if (idx == 4'd3) begin
            state_d = (CLEAR_CYCLES == 16'd0) ? S_IDLE : S_CLEAR_WAIT;
          end else begin
            idx_d = idx + 4'd1;
          end
        end
      end
      S_CLEAR_WAIT: begin
        if (cnt + 16'd1 >= CLEAR_CYCLES) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
        end
      end
      S_IDLE: begin
        cnt_d = 16'd0;
        idx_d = 4'd0;
        if (rows != shown) begin
          capture = 1'b1;
          state_d = S_LINE1;
        end
      end
      S_LINE1: begin
        if (byte_last) begin
          state_d = S_WR_TOP;
          cnt_d   = 16'd0;
          idx_d   = 4'd0;
        end
      end
      S_WR_TOP: begin
        if (byte_last) begin
          cnt_d = 16'd0;
          if (idx == 4'd15) state_d = S_LINE2;
          else              idx_d   = idx + 4'd1;
        end
      end
      S_LINE2: begin
        if (byte_last) begin
          state_d = S_WR_BOT;
          cnt_d   = 16'd0;
          idx_d   = 4'd0;
        end
      end
      S_WR_BOT: begin
        if (byte_last) begin
          cnt_d = 16'd0;
          if (idx == 4'd15) state_d = S_DONE;
          else              idx_d   = idx + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
      default: begin
        state_d = S_POWERUP;
        cnt_d   = 16'd0;
        idx_d   = 4'd0;
      end
    endcase

    // Output registers are loaded from next-state values so the bus is glitch-free.
    sending_d = (state_d == S_INIT)   || (state_d == S_LINE1) ||
                (state_d == S_WR_TOP) || (state_d == S_LINE2) ||
                (state_d == S_WR_BOT);
    en_d      = sending_d && (cnt_d < EN_LEN);
    load_d    = sending_d && (cnt_d == 16'd0);
    rs_d      = (state_d == S_WR_TOP) || (state_d == S_WR_BOT);
    char_base = 7'd127 - {idx_d, 3'b000};
    byte_d    = 8'h00;
    case (state_d)
      S_INIT:   byte_d = init_cmd(idx_d[1:0]);
      S_LINE1:  byte_d = 8'h80;
      S_LINE2:  byte_d = 8'hC0;
      S_WR_TOP: byte_d = snapshot[{1'b1, char_base} -: 8];
      S_WR_BOT: byte_d = snapshot[{1'b0, char_base} -: 8];
      default:  byte_d = 8'h00;
    endcase
  end

  // The snapshot stays frozen for a whole frame; only IDLE may refresh it.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      shown    <= BLANK;
      snapshot <= BLANK;
    end else if (capture) begin
      shown    <= rows;
      snapshot <= rows;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      lcd_en     <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      busy       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      lcd_en     <= en_d;
      busy       <= (state_d != S_IDLE);
      frame_done <= (state_d == S_DONE);
      if (load_d) begin
        lcd_rs   <= rs_d;
        lcd_data <= byte_d;
      end
    end
  end

endmodule

// File: tb/tb_lcd_row_writer.sv
// Bench for lcd_row_writer: bus monitor compares every latched byte against an
// expected queue; table vectors and hand sequences cover timing and corner cases.
module tb_lcd_row_writer;

  localparam int POWERUP_I = 20;
  localparam int EN_I      = 2;
  localparam int GAP_I     = 3;
  localparam int CLR_I     = 10;
  localparam int BYTE_T    = EN_I + GAP_I;
  localparam int FRAME_T   = 34 * BYTE_T;
  localparam logic [127:0] SPACES = {16{8'h20}};

  typedef struct {
    logic [127:0] top;
    logic [127:0] bottom;
    bit           frame;
  } vec_t;

  logic         clk = 1'b0;
  logic         nRst = 1'b0;
  logic [127:0] top;
  logic [127:0] bottom;
  logic         lcd_en;
  logic         lcd_rs;
  logic         lcd_rw;
  logic [7:0]   lcd_data;
  logic         busy;
  logic         frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];

  lcd_row_writer #(
    .POWERUP_CYCLES(16'(POWERUP_I)),
    .EN_CYCLES     (8'(EN_I)),
    .GAP_CYCLES    (8'(GAP_I)),
    .CLEAR_CYCLES  (16'(CLR_I))
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .top       (top),
    .bottom    (bottom),
    .lcd_en    (lcd_en),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_data  (lcd_data),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic push_frame(input logic [127:0] t, input logic [127:0] b);
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, t[127-8*i -: 8]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, b[127-8*i -: 8]});
  endtask

  // sel 0: lcd_en high, 1: busy low, 2: frame_done high
  task automatic wait_until(input int sel, input int limit, input string name, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < limit) begin
      @(posedge clk);
      #1;
      n++;
      case (sel)
        0:       hit = (lcd_en === 1'b1);
        1:       hit = (busy === 1'b0);
        default: hit = (frame_done === 1'b1);
      endcase
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no event, want one within %0d cycles", name, limit);
    end
  endtask

  // bus monitor: one latched byte per lcd_en falling edge
  logic       prev_en;
  int         hi_run;
  int         lo_run;
  logic [8:0] cur_byte;

  always @(negedge clk) begin
    if (!nRst) begin
      prev_en = 1'b0;
      hi_run  = 0;
      lo_run  = 1000;
    end else begin
      if (lcd_en && !prev_en) begin
        check("gap_min", (lo_run >= GAP_I) ? 1 : 0, 1);
        hi_run   = 1;
        cur_byte = {lcd_rs, lcd_data};
      end else if (lcd_en) begin
        hi_run++;
        check("hold_high", {lcd_rs, lcd_data}, cur_byte);
      end else if (prev_en) begin
        check("en_width", hi_run, EN_I);
        check("hold_fall", {lcd_rs, lcd_data}, cur_byte);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got 0x%0h, want no byte", cur_byte);
        end else begin
          check("lcd_byte", cur_byte, exp_q.pop_front());
        end
        lo_run = 1;
      end else begin
        if (lo_run < GAP_I) check("hold_gap", {lcd_rs, lcd_data}, cur_byte);
        lo_run++;
      end
      check("rw_low", lcd_rw, 1'b0);
      prev_en = lcd_en;
    end
  end

  initial begin
    int n;
    int en_hi;
    int busy_hi;
    int fd_hi;
    vec_t vecs[5];
    logic [127:0] row_a_top;
    logic [127:0] row_a_bot;
    logic [127:0] row_w;

    vecs[0].top = SPACES;             vecs[0].bottom = SPACES;             vecs[0].frame = 1'b0;
    vecs[1].top = "      _____     "; vecs[1].bottom = SPACES;             vecs[1].frame = 1'b1;
    vecs[2].top = "      _____     "; vecs[2].bottom = SPACES;             vecs[2].frame = 1'b0;
    vecs[3].top = 128'h0;             vecs[3].bottom = {16{8'hFF}};        vecs[3].frame = 1'b1;
    vecs[4].bottom = {16{8'hFF}};     vecs[4].frame = 1'b1;
    for (int k = 0; k < 4; k++) vecs[4].top[32*k +: 32] = $urandom();

    top    = SPACES;
    bottom = SPACES;
    nRst   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", lcd_en, 1'b0);
    check("rst_rs", lcd_rs, 1'b0);
    check("rst_rw", lcd_rw, 1'b0);
    check("rst_data", lcd_data, 8'h00);
    check("rst_busy", busy, 1'b1);
    check("rst_frame_done", frame_done, 1'b0);

    // power-up and init
    nRst = 1'b1;
    push_init();
    wait_until(0, 100, "powerup", n);
    check("powerup_len", n, POWERUP_I);
    check("init_first", {lcd_rs, lcd_data}, {1'b0, 8'h38});
    wait_until(1, 200, "init_done", n);
    check("init_to_idle", n, 4 * BYTE_T + CLR_I);
    check("init_bytes_left", exp_q.size(), 0);

    // table-driven frames
    foreach (vecs[v]) begin
      top    = vecs[v].top;
      bottom = vecs[v].bottom;
      if (vecs[v].frame) begin
        push_frame(vecs[v].top, vecs[v].bottom);
        wait_until(0, 5, "frame_start", n);
        check("frame_start_lat", n, 1);
        check("busy_in_frame", busy, 1'b1);
        wait_until(2, FRAME_T + 50, "frame_done", n);
        check("frame_len", n, FRAME_T);
        @(posedge clk);
        #1;
        check("done_one_cycle", frame_done, 1'b0);
        check("busy_after_done", busy, 1'b0);
        check("frame_bytes_left", exp_q.size(), 0);
      end else begin
        en_hi   = 0;
        busy_hi = 0;
        fd_hi   = 0;
        repeat (500) begin
          @(posedge clk);
          #1;
          if (lcd_en) en_hi++;
          if (busy) busy_hi++;
          if (frame_done) fd_hi++;
        end
        check("quiet_en", en_hi, 0);
        check("quiet_busy", busy_hi, 0);
        check("quiet_frame_done", fd_hi, 0);
      end
    end

    // row change while the bottom line is being written
    row_a_top = "ABCDEFGHIJKLMNOP";
    row_a_bot = "0123456789abcdef";
    top    = row_a_top;
    bottom = row_a_bot;
    push_frame(row_a_top, row_a_bot);
    wait_until(0, 5, "mid_start", n);
    repeat (20 * BYTE_T) begin
      @(posedge clk);
      #1;
    end
    check("mid_in_wr_bot", {lcd_rs, lcd_en}, 2'b11);
    row_w = row_a_top;
    row_w[127:120] = 8'h57;
    top = row_w;
    push_frame(row_w, row_a_bot);
    wait_until(2, FRAME_T, "mid_done1", n);
    check("mid_done1_at", n, FRAME_T - 20 * BYTE_T);
    wait_until(0, 10, "refire", n);
    check("refire_delay", n, 2);
    repeat (BYTE_T) begin
      @(posedge clk);
      #1;
    end
    check("w_first_char", {lcd_rs, lcd_data}, {1'b1, 8'h57});
    wait_until(2, FRAME_T + 10, "mid_done2", n);
    check("mid_done2_len", n, FRAME_T - BYTE_T);
    check("mid_bytes_left", exp_q.size(), 0);

    // reset in the middle of top-row byte 7
    top    = "reset during row";
    bottom = "line two text!!!";
    push_frame(top, bottom);
    wait_until(0, 5, "rst_start", n);
    repeat (8 * BYTE_T) begin
      @(posedge clk);
      #1;
    end
    check("rst_pre_en", lcd_en, 1'b1);
    check("rst_pre_byte", {lcd_rs, lcd_data}, {1'b1, 8'h75});
    nRst = 1'b0;
    #1;
    check("abort_en", lcd_en, 1'b0);
    check("abort_data", lcd_data, 8'h00);
    check("abort_rs", lcd_rs, 1'b0);
    check("abort_frame_done", frame_done, 1'b0);
    check("abort_busy", busy, 1'b1);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    nRst = 1'b1;
    push_init();
    push_frame(top, bottom);
    wait_until(0, 100, "re_powerup", n);
    check("re_powerup_len", n, POWERUP_I);
    check("re_init_first", {lcd_rs, lcd_data}, {1'b0, 8'h38});
    wait_until(1, 200, "re_init_done", n);
    check("re_init_to_idle", n, 4 * BYTE_T + CLR_I);
    wait_until(2, FRAME_T + 20, "re_frame_done", n);
    check("re_frame_len", n, FRAME_T + 1);
    @(posedge clk);
    #1;
    check("final_bytes_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
